// File: rtl/cmd_arb_if.sv
// cmd_arb_if
// Bundles the command-arbiter signals: the two command sources (remote, tour),
// the cmd_proc command port and the UART response path.
// modport slave  : the arbiter side (cmd_arb).
// modport master : the surrounding system (sources, cmd_proc, UART).
// Signals:
//   rmt_cmd/rmt_rdy/rmt_clr     remote command word, valid level, consumed pulse
//   tour_cmd/tour_rdy/tour_clr  tour command word, valid level, consumed pulse
//   tour_mode/tour_fin          tour in progress, tour complete pulse
//   cmd/cmd_rdy/clr_cmd_rdy     command to cmd_proc, valid level, accept
//   cmd_done/tour_ack           command finished, tour command completed pulse
//   tx_busy/resp/snd_resp       UART busy, response byte, send pulse
//   owner/busy                  current owner (1 = tour), command in flight
interface cmd_arb_if;
   logic [15:0] rmt_cmd;
   logic        rmt_rdy;
   logic        rmt_clr;
   logic [15:0] tour_cmd;
   logic        tour_rdy;
   logic        tour_clr;
   logic        tour_mode;
   logic        tour_fin;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        cmd_done;
   logic        tour_ack;
   logic        tx_busy;
   logic [7:0]  resp;
   logic        snd_resp;
   logic        owner;
   logic        busy;

   modport slave (
      input  rmt_cmd, rmt_rdy, tour_cmd, tour_rdy, tour_mode, tour_fin,
             clr_cmd_rdy, cmd_done, tx_busy,
      output rmt_clr, tour_clr, cmd, cmd_rdy, tour_ack, resp, snd_resp,
             owner, busy
   );

   modport master (
      output rmt_cmd, rmt_rdy, tour_cmd, tour_rdy, tour_mode, tour_fin,
             clr_cmd_rdy, cmd_done, tx_busy,
      input  rmt_clr, tour_clr, cmd, cmd_rdy, tour_ack, resp, snd_resp,
             owner, busy
   );
endinterface

// File: rtl/cmd_arb.sv
// cmd_arb
// Arbitrates between the remote command path and the tour command generator
// for the single cmd_proc command port. One command is latched at a time,
// its completion is tracked with a timeout guard, and completions are routed
// to the owner: remote completions and timeouts become ACK/NAK response bytes,
// tour completions become tour_ack pulses. tour_fin also queues an ACK.
// Response bytes pass through a 2-entry FIFO toward the UART.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    cmd_arb_if.slave (see cmd_arb_if.sv for the signal list)
// Parameters:
//   TMO_W  timeout counter width; timeout fires at count 2^TMO_W-1
//   ACK    positive-acknowledge byte
//   NAK    negative-acknowledge (timeout) byte
module cmd_arb #(
   parameter int          TMO_W = 24,
   parameter logic [7:0]  ACK   = 8'hA5,
   parameter logic [7:0]  NAK   = 8'h5A
) (
   input  logic      clk,
   input  logic      rst_n,
   cmd_arb_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;

   // Counter value during the last WAIT_DONE cycle: the count reaches
   // all-ones on the same edge that moves the FSM to COMPLETE.
   localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

   state_t            state, state_nxt;
   logic              grant_rmt, grant_tour;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              done_ok;
   logic [15:0]       cmd_q;
   logic              owner_q;
   logic              rmt_clr_q, tour_clr_q;
   logic              snd_prev;
   logic              snd_now;
   logic              push_cmp;
   logic [7:0]        cmp_byte;
   logic [7:0]        q0, q1, q0_nxt, q1_nxt;
   logic [1:0]        q_cnt, q_cnt_nxt;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and grant decision. In tour mode only the tour source is
   // served; a pending remote request simply waits for tour_mode to drop.
   always_comb begin
      state_nxt  = state;
      grant_rmt  = 1'b0;
      grant_tour = 1'b0;
      case (state)
         IDLE: begin
            if (bus.tour_mode) begin
               if (bus.tour_rdy) grant_tour = 1'b1;
            end else if (bus.rmt_rdy) begin
               grant_rmt = 1'b1;
            end else if (bus.tour_rdy) begin
               grant_tour = 1'b1;
            end
            if (grant_rmt || grant_tour) state_nxt = ISSUE;
         end
         ISSUE:     if (bus.clr_cmd_rdy) state_nxt = WAIT_DONE;
         WAIT_DONE: if (bus.cmd_done || tmo_cnt == TMO_LAST) state_nxt = COMPLETE;
         COMPLETE:  state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Command latch, owner, consume pulses, timeout counter and completion
   // status. done_ok follows cmd_done throughout WAIT_DONE so it holds the
   // reason for leaving (done vs timeout) while in COMPLETE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q      <= '0;
         owner_q    <= 1'b0;
         rmt_clr_q  <= 1'b0;
         tour_clr_q <= 1'b0;
         tmo_cnt    <= '0;
         done_ok    <= 1'b0;
      end else begin
         rmt_clr_q  <= grant_rmt;
         tour_clr_q <= grant_tour;
         if (grant_rmt) begin
            cmd_q   <= bus.rmt_cmd;
            owner_q <= 1'b0;
         end else if (grant_tour) begin
            cmd_q   <= bus.tour_cmd;
            owner_q <= 1'b1;
         end
         tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
         if (state == WAIT_DONE) done_ok <= bus.cmd_done;
      end
   end

   // Response FIFO next-state: pop first, then the COMPLETE byte, then the
   // tour_fin ACK. Bytes arriving with no free slot are dropped.
   always_comb begin
      q0_nxt    = q0;
      q1_nxt    = q1;
      q_cnt_nxt = q_cnt;
      if (snd_now) begin
         q0_nxt    = q1;
         q_cnt_nxt = q_cnt - 1'b1;
      end
      if (push_cmp && q_cnt_nxt != 2'd2) begin
         if (q_cnt_nxt == 2'd0) q0_nxt = cmp_byte;
         else                   q1_nxt = cmp_byte;
         q_cnt_nxt = q_cnt_nxt + 1'b1;
      end
      if (bus.tour_fin && q_cnt_nxt != 2'd2) begin
         if (q_cnt_nxt == 2'd0) q0_nxt = ACK;
         else                   q1_nxt = ACK;
         q_cnt_nxt = q_cnt_nxt + 1'b1;
      end
   end

   // Response FIFO storage and send spacing (no back-to-back snd_resp).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q0       <= '0;
         q1       <= '0;
         q_cnt    <= '0;
         snd_prev <= 1'b0;
      end else begin
         q0       <= q0_nxt;
         q1       <= q1_nxt;
         q_cnt    <= q_cnt_nxt;
         snd_prev <= snd_now;
      end
   end

   // Tour-owned successful completions are answered with tour_ack instead
   // of a byte; every other completion (remote ok, any timeout) queues one.
   assign push_cmp = (state == COMPLETE) && !(owner_q && done_ok);
   assign cmp_byte = done_ok ? ACK : NAK;
   assign snd_now  = (q_cnt != 2'd0) && !bus.tx_busy && !snd_prev;

   assign bus.cmd      = cmd_q;
   assign bus.cmd_rdy  = (state == ISSUE);
   assign bus.rmt_clr  = rmt_clr_q;
   assign bus.tour_clr = tour_clr_q;
   assign bus.tour_ack = (state == COMPLETE) && owner_q && done_ok;
   assign bus.resp     = (q_cnt != 2'd0) ? q0 : 8'h00;
   assign bus.snd_resp = snd_now;
   assign bus.owner    = owner_q;
   assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_cmd_arb.sv
// tb_cmd_arb
// Randomized bench for cmd_arb. A transaction-level reference model (active
// command record, wait-cycle tally, byte queue) predicts every output each
// cycle. Phases bias the stimulus toward normal traffic, timeouts, UART
// backpressure with queue overflow, long tour-mode runs and random resets.
module tb_cmd_arb;
   localparam int         TMO_W = 4;
   localparam logic [7:0] ACK   = 8'hA5;
   localparam logic [7:0] NAK   = 8'h5A;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmd_arb_if bus ();

   cmd_arb #(.TMO_W(TMO_W), .ACK(ACK), .NAK(NAK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   // Reference model state.
   bit          m_active, m_owner, m_await, m_fin, m_ok;
   bit          m_rclr, m_tclr, m_sent_prev;
   logic [15:0] m_cmd;
   int          m_wait;
   logic [7:0]  mq[$];
   bit          e_snd;

   // One comparison: count it and report a mismatch.
   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
      end
   endtask

   task automatic modelReset();
      m_active = 0; m_owner = 0; m_await = 0; m_fin = 0; m_ok = 0;
      m_rclr = 0; m_tclr = 0; m_sent_prev = 0;
      m_cmd = '0; m_wait = 0;
      mq.delete();
   endtask

   // Compare every DUT output against the model's prediction for this cycle.
   task automatic checkCycle();
      logic [7:0] e_resp;
      e_snd  = (mq.size() > 0) && !bus.tx_busy && !m_sent_prev;
      e_resp = (mq.size() > 0) ? mq[0] : 8'h00;
      checkOutput("cmd",      bus.cmd,      m_cmd);
      checkOutput("cmd_rdy",  bus.cmd_rdy,  m_active && m_await);
      checkOutput("rmt_clr",  bus.rmt_clr,  m_rclr);
      checkOutput("tour_clr", bus.tour_clr, m_tclr);
      checkOutput("tour_ack", bus.tour_ack, m_fin && m_owner && m_ok);
      checkOutput("snd_resp", bus.snd_resp, e_snd);
      checkOutput("resp",     bus.resp,     e_resp);
      checkOutput("owner",    bus.owner,    m_owner);
      checkOutput("busy",     bus.busy,     m_active);
   endtask

   // Advance the model by one clock using this cycle's inputs.
   task automatic modelStep();
      if (!rst_n) begin
         modelReset();
         return;
      end
      if (e_snd) void'(mq.pop_front());
      m_sent_prev = e_snd;
      if (m_fin && !(m_owner && m_ok) && mq.size() < 2) mq.push_back(m_ok ? ACK : NAK);
      if (bus.tour_fin && mq.size() < 2) mq.push_back(ACK);
      m_rclr = 0;
      m_tclr = 0;
      if (m_fin) begin
         m_fin    = 0;
         m_active = 0;
      end else if (!m_active) begin
         if (bus.rmt_rdy && !bus.tour_mode) begin
            m_active = 1; m_owner = 0; m_cmd = bus.rmt_cmd; m_rclr = 1; m_await = 1;
         end else if (bus.tour_rdy) begin
            m_active = 1; m_owner = 1; m_cmd = bus.tour_cmd; m_tclr = 1; m_await = 1;
         end
      end else if (m_await) begin
         if (bus.clr_cmd_rdy) begin
            m_await = 0;
            m_wait  = 0;
         end
      end else begin
         if (bus.cmd_done) begin
            m_fin = 1; m_ok = 1;
         end else begin
            m_wait++;
            if (m_wait == (1 << TMO_W) - 1) begin
               m_fin = 1; m_ok = 0;
            end
         end
      end
   endtask

   // Drive one cycle of random inputs; knobs are per-mille probabilities.
   // Sources drop their request in the cycle their consume pulse appears.
   task automatic applyStimulus(input int p_done, input int p_busy, input int p_fin,
                                input int p_mode, input int p_rst);
      rst_n = ($urandom_range(999) >= p_rst);
      if (m_rclr) bus.rmt_rdy = 1'b0;
      else if (!bus.rmt_rdy && $urandom_range(99) < 30) begin
         bus.rmt_rdy = 1'b1;
         bus.rmt_cmd = 16'($urandom);
      end
      if (m_tclr) bus.tour_rdy = 1'b0;
      else if (!bus.tour_rdy && $urandom_range(99) < 30) begin
         bus.tour_rdy = 1'b1;
         bus.tour_cmd = 16'($urandom);
      end
      if ($urandom_range(999) < p_mode) bus.tour_mode = ~bus.tour_mode;
      bus.clr_cmd_rdy = ($urandom_range(99) < 40);
      bus.cmd_done    = ($urandom_range(999) < p_done);
      bus.tour_fin    = ($urandom_range(999) < p_fin);
      if ($urandom_range(99) < 25) bus.tx_busy = ($urandom_range(999) < p_busy);
   endtask

   task automatic runPhase(input int n, input int p_done, input int p_busy, input int p_fin,
                           input int p_mode, input int p_rst);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cycle++;
         applyStimulus(p_done, p_busy, p_fin, p_mode, p_rst);
         @(negedge clk);
         checkCycle();
         modelStep();
      end
   endtask

   initial begin
      bus.rmt_cmd = '0; bus.rmt_rdy = 1'b0; bus.tour_cmd = '0; bus.tour_rdy = 1'b0;
      bus.tour_mode = 1'b0; bus.tour_fin = 1'b0; bus.clr_cmd_rdy = 1'b0;
      bus.cmd_done = 1'b0; bus.tx_busy = 1'b0;
      rst_n = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_cmd",      bus.cmd,      16'h0000);
      checkOutput("rst_cmd_rdy",  bus.cmd_rdy,  16'h0);
      checkOutput("rst_rmt_clr",  bus.rmt_clr,  16'h0);
      checkOutput("rst_tour_clr", bus.tour_clr, 16'h0);
      checkOutput("rst_tour_ack", bus.tour_ack, 16'h0);
      checkOutput("rst_resp",     bus.resp,     16'h0000);
      checkOutput("rst_snd_resp", bus.snd_resp, 16'h0);
      checkOutput("rst_owner",    bus.owner,    16'h0);
      checkOutput("rst_busy",     bus.busy,     16'h0);

      // Normal mixed traffic with occasional resets.
      runPhase(800, 150, 200, 20, 10, 2);
      // No completions: every command times out with NAK.
      runPhase(600,   0, 300, 20, 10, 2);
      // UART mostly busy: queue fills, simultaneous enqueues, overflow drops.
      runPhase(600, 200, 850, 60, 10, 0);
      // Long tour-mode stretch: tour priority, remote held off.
      @(posedge clk);
      #1;
      bus.tour_mode = 1'b1;
      runPhase(600, 150, 100, 10,  0, 0);
      // Frequent resets, including mid-command.
      runPhase(600, 100, 200, 20, 20, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
